// File: rtl/key_event_decoder.sv
// Turns a debounced key level into PRESS / RELEASE / LONG / REPEAT events,
// delivered one at a time on a valid/ready port with a sticky drop flag.
module key_event_decoder #(
  parameter int unsigned      WIDTH        = 20,
  parameter logic [WIDTH-1:0] LONG_COUNT   = 20'd500000,
  parameter logic [WIDTH-1:0] REPEAT_COUNT = 20'd100000
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iKey,
  input  logic       iEvt_ready,
  input  logic       iOvf_clr,
  output logic       oEvt_valid,
  output logic [1:0] oEvt_code,
  output logic       oHeld,
  output logic       oLong_held,
  output logic       oOverflow
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_REPEAT  = 2'd2
  } state_t;

  localparam logic [1:0] EVT_PRESS   = 2'b00;
  localparam logic [1:0] EVT_RELEASE = 2'b01;
  localparam logic [1:0] EVT_LONG    = 2'b10;
  localparam logic [1:0] EVT_REPEAT  = 2'b11;

  localparam logic [WIDTH-1:0] LONG_LAST   = LONG_COUNT - 1'b1;
  localparam logic [WIDTH-1:0] REPEAT_LAST = REPEAT_COUNT - 1'b1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             key_q, key_d;
  logic             evt_valid_q, evt_valid_d;
  logic [1:0]       evt_code_q, evt_code_d;
  logic             ovf_q, ovf_d;

  logic       rise, fall;
  logic       gen;
  logic [1:0] gen_code;

  assign rise  = iKey & ~key_q;
  assign fall  = ~iKey & key_q;
  assign key_d = iKey;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      key_q       <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= EVT_PRESS;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      ovf_q       <= ovf_d;
    end
  end

  // Hold tracking: a fall always takes priority over a counter terminal.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gen      = 1'b0;
    gen_code = EVT_PRESS;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          gen      = 1'b1;
          gen_code = EVT_PRESS;
          cnt_d    = '0;
          state_d  = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        if (fall) begin
          gen      = 1'b1;
          gen_code = EVT_RELEASE;
          state_d  = ST_IDLE;
        end else if (cnt_q == LONG_LAST) begin
          gen      = 1'b1;
          gen_code = EVT_LONG;
          cnt_d    = '0;
          state_d  = ST_REPEAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (fall) begin
          gen      = 1'b1;
          gen_code = EVT_RELEASE;
          state_d  = ST_IDLE;
        end else if (cnt_q == REPEAT_LAST) begin
          gen      = 1'b1;
          gen_code = EVT_REPEAT;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Single-entry event slot; a new event replaces the pending one only when
  // the pending one is being accepted on the same edge, otherwise it is lost.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    ovf_d       = ovf_q & ~iOvf_clr;
    if (gen) begin
      if (!evt_valid_q || iEvt_ready) begin
        evt_valid_d = 1'b1;
        evt_code_d  = gen_code;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (evt_valid_q && iEvt_ready) begin
      evt_valid_d = 1'b0;
    end
  end

  assign oEvt_valid = evt_valid_q;
  assign oEvt_code  = evt_code_q;
  assign oHeld      = (state_q != ST_IDLE);
  assign oLong_held = (state_q == ST_REPEAT);
  assign oOverflow  = ovf_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Drives two decoders (long/repeat 8/4 and 2/3) with directed and random key
// activity and compares every cycle against a hold-time reference model.
module tb_key_event_decoder;

  localparam int LC[2] = '{8, 2};
  localparam int RC[2] = '{4, 3};

  logic       iClk = 1'b0;
  logic       iRst_n;
  logic       iKey;
  logic       iEvt_ready;
  logic       iOvf_clr;
  logic       vld   [2];
  logic [1:0] code  [2];
  logic       held  [2];
  logic       lheld [2];
  logic       ovf   [2];

  int errors = 0;
  int checks = 0;

  // reference model state
  logic       m_key;
  logic       m_held [2];
  int         m_t    [2];
  logic       m_v    [2];
  logic [1:0] m_code [2];
  logic       m_ovf  [2];

  always #5 iClk = ~iClk;

  key_event_decoder #(.WIDTH(8), .LONG_COUNT(8'd8), .REPEAT_COUNT(8'd4)) dut0 (
    .iClk(iClk), .iRst_n(iRst_n), .iKey(iKey), .iEvt_ready(iEvt_ready),
    .iOvf_clr(iOvf_clr), .oEvt_valid(vld[0]), .oEvt_code(code[0]),
    .oHeld(held[0]), .oLong_held(lheld[0]), .oOverflow(ovf[0])
  );

  key_event_decoder #(.WIDTH(8), .LONG_COUNT(8'd2), .REPEAT_COUNT(8'd3)) dut1 (
    .iClk(iClk), .iRst_n(iRst_n), .iKey(iKey), .iEvt_ready(iEvt_ready),
    .iOvf_clr(iOvf_clr), .oEvt_valid(vld[1]), .oEvt_code(code[1]),
    .oHeld(held[1]), .oLong_held(lheld[1]), .oOverflow(ovf[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_key = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_held[k] = 1'b0;
      m_t[k]    = 0;
      m_v[k]    = 1'b0;
      m_code[k] = 2'b00;
      m_ovf[k]  = 1'b0;
    end
  endtask

  // Events derive from the number of edges elapsed since the press edge:
  // LONG at t == LC, REPEAT whenever t - LC is a positive multiple of RC.
  task automatic model_step();
    logic       ev;
    logic [1:0] evc;
    for (int k = 0; k < 2; k++) begin
      ev  = 1'b0;
      evc = 2'b00;
      if (!m_held[k]) begin
        if (iKey && !m_key) begin
          ev = 1'b1; evc = 2'b00; m_held[k] = 1'b1; m_t[k] = 0;
        end
      end else if (!iKey && m_key) begin
        ev = 1'b1; evc = 2'b01; m_held[k] = 1'b0;
      end else begin
        m_t[k] = m_t[k] + 1;
        if (m_t[k] == LC[k]) begin
          ev = 1'b1; evc = 2'b10;
        end else if (m_t[k] > LC[k] && ((m_t[k] - LC[k]) % RC[k]) == 0) begin
          ev = 1'b1; evc = 2'b11;
        end
      end
      m_ovf[k] = m_ovf[k] & ~iOvf_clr;
      if (ev) begin
        if (!m_v[k] || iEvt_ready) begin
          m_v[k] = 1'b1; m_code[k] = evc;
        end else begin
          m_ovf[k] = 1'b1;
        end
      end else if (m_v[k] && iEvt_ready) begin
        m_v[k] = 1'b0;
      end
    end
    m_key = iKey;
  endtask

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("valid%0d", k), 32'(vld[k]), 32'(m_v[k]));
      check($sformatf("code%0d", k), 32'(code[k]), 32'(m_code[k]));
      check($sformatf("held%0d", k), 32'(held[k]), 32'(m_held[k]));
      check($sformatf("long_held%0d", k), 32'(lheld[k]),
            32'(m_held[k] && (m_t[k] >= LC[k])));
      check($sformatf("overflow%0d", k), 32'(ovf[k]), 32'(m_ovf[k]));
    end
  endtask

  task automatic cycle();
    @(posedge iClk);
    if (iRst_n) model_step();
    @(negedge iClk);
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic async_reset(input logic key_during);
    #2 iRst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_valid", 32'(vld[k]), 32'd0);
      check("rst_code", 32'(code[k]), 32'd0);
      check("rst_held", 32'(held[k]), 32'd0);
      check("rst_long_held", 32'(lheld[k]), 32'd0);
      check("rst_overflow", 32'(ovf[k]), 32'd0);
    end
    model_reset();
    iKey = key_during;
    run(2);
    iRst_n = 1'b1;
  endtask

  initial begin
    iRst_n = 1'b0; iKey = 1'b0; iEvt_ready = 1'b1; iOvf_clr = 1'b0;
    model_reset();
    run(2);
    iRst_n = 1'b1;
    run(2);

    // short press, ready always high
    iKey = 1'b1; run(5);
    iKey = 1'b0; run(6);
    // long hold through LONG and several REPEATs
    iKey = 1'b1; run(20);
    iKey = 1'b0; run(4);
    // release lands on the LONG terminal edge of dut0
    iKey = 1'b1; run(8);
    iKey = 1'b0; run(4);
    // stalled consumer: RELEASE dropped, PRESS held
    iEvt_ready = 1'b0;
    iKey = 1'b1; run(1);
    iKey = 1'b0; run(3);
    check("stall_code0", 32'(code[0]), 32'd0);
    check("stall_ovf0", 32'(ovf[0]), 32'd1);
    iEvt_ready = 1'b1; run(1);
    iEvt_ready = 1'b0; iOvf_clr = 1'b1; run(1);
    iOvf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf[0]), 32'd0);
    iKey = 1'b1; run(1);
    iKey = 1'b0; iOvf_clr = 1'b1; run(1);
    iOvf_clr = 1'b0;
    check("clr_vs_drop", 32'(ovf[0]), 32'd1);
    iEvt_ready = 1'b1; iOvf_clr = 1'b1; run(1);
    iOvf_clr = 1'b0; run(2);
    // back-to-back PRESS then LONG on dut1
    iKey = 1'b1; run(1);
    check("b2b_press", 32'({vld[1], code[1]}), 32'({1'b1, 2'b00}));
    run(2);
    check("b2b_long", 32'({vld[1], code[1], ovf[1]}), 32'({1'b1, 2'b10, 1'b0}));
    run(3);
    iKey = 1'b0; run(3);
    // reset while in REPEAT with an event pending, key still down
    iKey = 1'b1; run(13);
    iEvt_ready = 1'b0; run(1);
    async_reset(1'b1);
    iEvt_ready = 1'b1;
    run(1);
    check("post_rst_press", 32'({vld[0], code[0], held[0]}), 32'({1'b1, 2'b00, 1'b1}));
    run(3);
    iKey = 1'b0; run(3);

    // random activity
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) iKey = ~iKey;
      iEvt_ready = ($urandom_range(0, 3) != 0);
      iOvf_clr   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 799) == 0) async_reset(1'($urandom_range(0, 1)));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
